// File: rtl/branch_res_queue_cu_if.sv
// rtl/branch_res_queue_cu_if.sv - branch resolution queue channel/frontend/issue bundle
interface branch_res_queue_cu_if #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     flush_i;
    logic [NUM_CH-1:0]        ch_valid_i;
    logic [NUM_CH-1:0]        ch_ready_o;
    logic [NUM_CH-1:0]        ch_mis_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_i;
    logic                     issue_mis_o;
    logic [CH_W-1:0]          issue_mis_ch_o;
    logic                     fe_valid_o;
    logic                     fe_ready_i;
    logic [DATA_W-1:0]        fe_data_o;
    logic                     fe_mis_o;
    logic [CNT_W-1:0]         count_o;

    // environment side: branch units, frontend and flush source
    modport master (
        output flush_i, ch_valid_i, ch_mis_i, ch_data_i, fe_ready_i,
        input  ch_ready_o, issue_mis_o, issue_mis_ch_o, fe_valid_o, fe_data_o, fe_mis_o, count_o
    );

    // control unit side
    modport slave (
        input  flush_i, ch_valid_i, ch_mis_i, ch_data_i, fe_ready_i,
        output ch_ready_o, issue_mis_o, issue_mis_ch_o, fe_valid_o, fe_data_o, fe_mis_o, count_o
    );
endinterface

// File: rtl/branch_res_queue_cu.sv
// rtl/branch_res_queue_cu.sv - multi-channel branch resolution FIFO with misprediction drain/stall
module branch_res_queue_cu #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input logic                   clk_i,
    input logic                   rst_i,
    branch_res_queue_cu_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {RUN, MIS_NOTIFY, MIS_DRAIN, STALL} state_t;

    state_t            state_q, state_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CH_W-1:0]   mis_ch_q;

    logic              accept_ok;
    logic              found;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              push_mis;
    logic [DATA_W-1:0] push_data;
    logic              push;
    logic              pop;
    logic              fe_valid;
    logic              head_mis;

    // fixed-priority arbiter: lowest valid channel wins, only while RUN with room; reset forces zero
    always_comb begin
        accept_ok = (state_q == RUN) && (count_q < CNT_W'(DEPTH)) && !rst_i;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        push_mis  = 1'b0;
        push_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && bus.ch_valid_i[i]) begin
                found     = 1'b1;
                grant_idx = CH_W'(i);
                push_mis  = bus.ch_mis_i[i];
                push_data = bus.ch_data_i[i*DATA_W +: DATA_W];
                grant[i]  = accept_ok;
            end
        end
    end

    assign push     = found && accept_ok;
    assign head_mis = mem_q[rd_ptr_q][DATA_W];
    assign fe_valid = (count_q != '0) && (state_q != STALL);
    assign pop      = fe_valid && bus.fe_ready_i;

    assign bus.ch_ready_o     = grant;
    assign bus.fe_valid_o     = fe_valid;
    assign bus.fe_data_o      = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.fe_mis_o       = head_mis;
    assign bus.count_o        = count_q;
    assign bus.issue_mis_o    = (state_q == MIS_NOTIFY);
    assign bus.issue_mis_ch_o = mis_ch_q;

    // next-state: the mis entry may already leave during the notify cycle when it sits at the head
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:        if (push && push_mis) state_d = MIS_NOTIFY;
            MIS_NOTIFY: state_d = (pop && head_mis) ? STALL : MIS_DRAIN;
            MIS_DRAIN:  if (pop && head_mis) state_d = STALL;
            STALL:      state_d = STALL;
            default:    state_d = RUN;
        endcase
        if (bus.flush_i) state_d = RUN;
    end

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FIFO storage, pointers and occupancy; flush discards any push/pop of its cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mis_ch_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_mis, push_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (push && push_mis) mis_ch_q <= grant_idx;
        end
    end
endmodule

// File: tb/tb_branch_res_queue_cu.sv
// tb/tb_branch_res_queue_cu.sv - self-checking bench for branch_res_queue_cu
module tb_branch_res_queue_cu;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    typedef struct {
        logic              mis;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_res_queue_cu_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) b ();
    branch_res_queue_cu #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    int total = 0;
    int bad   = 0;

    // reference model: queue of entries plus architectural flags
    ent_t mq[$];
    bit   m_mis_pend = 0;   // a mispredict was accepted; no accepts until flush
    bit   m_stall    = 0;   // mispredicted entry has left; frontend blocked
    bit   m_notify   = 0;   // issue pulse expected this cycle
    int   m_mis_ch   = 0;
    int   m_pushes   = 0;
    int   m_pops     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] m,
                         input logic [63:0] d0, input logic [63:0] d1);
        b.ch_valid_i = v;
        b.ch_mis_i   = m;
        b.ch_data_i  = {d1, d0};
    endtask

    // one clock: check outputs against model, advance model with the inputs the DUT samples
    task automatic cycle();
        logic [NUM_CH-1:0] er;
        logic              efv;
        int                idx;
        ent_t              h;
        ent_t              e;
        #1;
        er  = '0;
        idx = -1;
        if (!m_mis_pend && mq.size() < DEPTH) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (b.ch_valid_i[i]) begin
                    er[i] = 1'b1;
                    idx   = i;
                    break;
                end
            end
        end
        efv = (mq.size() != 0) && !m_stall;
        chk("ready", 64'(b.ch_ready_o), 64'(er));
        chk("fe_valid", 64'(b.fe_valid_o), 64'(efv));
        chk("count", 64'(b.count_o), 64'(mq.size()));
        chk("issue_mis", 64'(b.issue_mis_o), 64'(m_notify));
        if (m_notify) chk("issue_ch", 64'(b.issue_mis_ch_o), 64'(m_mis_ch));
        if (efv) begin
            chk("fe_data", b.fe_data_o, mq[0].data);
            chk("fe_mis", 64'(b.fe_mis_o), 64'(mq[0].mis));
        end
        if (b.flush_i) begin
            mq.delete();
            m_mis_pend = 0;
            m_stall    = 0;
            m_notify   = 0;
        end else begin
            m_notify = 0;
            if (efv && b.fe_ready_i) begin
                h = mq.pop_front();
                m_pops++;
                if (h.mis) m_stall = 1;
            end
            if (idx >= 0) begin
                e.mis  = b.ch_mis_i[idx];
                e.data = b.ch_data_i[idx*DATA_W +: DATA_W];
                mq.push_back(e);
                m_pushes++;
                if (e.mis) begin
                    m_mis_pend = 1;
                    m_notify   = 1;
                    m_mis_ch   = idx;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        int start;
        b.flush_i    = 1'b0;
        b.fe_ready_i = 1'b0;
        drive(2'b11, 2'b00, 64'h0, 64'h0);

        // reset held three cycles with every channel requesting
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_ready", 64'(b.ch_ready_o), 64'h0);
            chk("rst_fe_valid", 64'(b.fe_valid_o), 64'h0);
            chk("rst_issue", 64'(b.issue_mis_o), 64'h0);
            chk("rst_count", 64'(b.count_o), 64'h0);
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        @(negedge clk);

        // ordering: ch0 wins first, then ch1
        b.fe_ready_i = 1'b1;
        drive(2'b11, 2'b00, 64'hA0, 64'hB0);
        cycle();
        chk("ord_a0", b.fe_data_o, 64'hA0);
        chk("ord_a0_valid", 64'(b.fe_valid_o), 64'h1);
        drive(2'b10, 2'b00, 64'hA0, 64'hB0);
        cycle();
        chk("ord_b0", b.fe_data_o, 64'hB0);
        chk("ord_b0_mis", 64'(b.fe_mis_o), 64'h0);
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        cycle();
        cycle();

        // full FIFO, then pop, then push+pop
        b.fe_ready_i = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(2'b01, 2'b00, 64'(i), 64'h0);
            cycle();
        end
        chk("full_count", 64'(b.count_o), 64'(DEPTH));
        chk("full_ready", 64'(b.ch_ready_o), 64'h0);
        drive(2'b01, 2'b00, 64'h55, 64'h0);
        cycle();
        b.fe_ready_i = 1'b1;
        cycle();
        chk("full_reassert", 64'(b.ch_ready_o), 64'h1);
        cycle();
        cycle();
        chk("pushpop_count", 64'(b.count_o), 64'(DEPTH - 1));
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin cycle(); guard++; end
        chk("full_drain", 64'(b.count_o), 64'h0);

        // misprediction: two pending, then mixed mis/non-mis, then mis on ch1
        b.fe_ready_i = 1'b0;
        drive(2'b01, 2'b00, 64'h11, 64'h0);
        cycle();
        drive(2'b01, 2'b00, 64'h22, 64'h0);
        cycle();
        drive(2'b11, 2'b10, 64'h33, 64'hC0);
        cycle();
        chk("mix_count", 64'(b.count_o), 64'h3);
        drive(2'b10, 2'b10, 64'h0, 64'hC0);
        cycle();
        chk("mis_pulse", 64'(b.issue_mis_o), 64'h1);
        chk("mis_ch", 64'(b.issue_mis_ch_o), 64'h1);
        drive(2'b11, 2'b00, 64'h44, 64'h0);
        b.fe_ready_i = 1'b1;
        cycle();
        chk("mis_pulse_end", 64'(b.issue_mis_o), 64'h0);
        start = m_pops;
        guard = 0;
        while (!m_stall && guard < 20) begin cycle(); guard++; end
        chk("mis_drained", 64'(m_stall && guard < 20), 64'h1);
        chk("mis_pops", 64'(m_pops - start), 64'h3);
        for (int i = 0; i < 20; i++) begin
            chk("stall_fe_valid", 64'(b.fe_valid_o), 64'h0);
            chk("stall_ready", 64'(b.ch_ready_o), 64'h0);
            cycle();
        end
        b.flush_i = 1'b1;
        cycle();
        b.flush_i = 1'b0;
        #1;
        chk("flush_stall_count", 64'(b.count_o), 64'h0);
        chk("flush_stall_ready", 64'(b.ch_ready_o), 64'h1);
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        @(negedge clk);

        // flush while draining with three entries queued
        b.fe_ready_i = 1'b0;
        drive(2'b01, 2'b00, 64'h61, 64'h0);
        cycle();
        drive(2'b01, 2'b00, 64'h62, 64'h0);
        cycle();
        drive(2'b10, 2'b10, 64'h0, 64'h63);
        cycle();
        drive(2'b11, 2'b00, 64'h64, 64'h65);
        cycle();
        chk("drain_count", 64'(b.count_o), 64'h3);
        b.flush_i = 1'b1;
        cycle();
        b.flush_i = 1'b0;
        #1;
        chk("flush_drain_count", 64'(b.count_o), 64'h0);
        chk("flush_drain_ready", 64'(b.ch_ready_o), 64'h1);
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        @(negedge clk);

        // wrap: random stream with backpressure, non-mis only
        start = m_pushes;
        guard = 0;
        while ((m_pushes - start) < 3*DEPTH+1 && guard < 2000) begin
            drive(2'($urandom_range(0, 3)), 2'b00, {$urandom, $urandom}, {$urandom, $urandom});
            b.fe_ready_i = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        chk("wrap_budget", 64'(guard < 2000), 64'h1);
        drive(2'b00, 2'b00, 64'h0, 64'h0);
        b.fe_ready_i = 1'b1;
        guard = 0;
        while (mq.size() != 0 && guard < 50) begin cycle(); guard++; end
        cycle();
        chk("wrap_empty", 64'(b.count_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
